pio_poll_master: RTL

Avalon-MM read master that periodically polls a single-register input PIO slave, such as the switch port on the lab7 SoC fabric. It issues one read every POLL_DIV clocks and captures the low DATA_W bits of the returned word. It keeps a running sum of every sample that differs from the previous one. It lets fabric logic see a slave-side input port without CPU involvement.

---
 rtl/pio_poll_if.sv | 23 ++
 rtl/pio_poll_master.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pio_poll_if.sv
// Avalon-MM read-only bus bundle between the PIO poller and its slave.
interface pio_poll_if #(
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/pio_poll_master.sv
// Periodic Avalon-MM poller of a single PIO register with change detection
// and a wrapping sum of every sample that differs from its predecessor.
module pio_poll_master #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int READ_ADDR = 0,
  parameter int POLL_DIV  = 50000,
  parameter int ACC_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  pio_poll_if.master        avm,
  input  logic              enable,
  input  logic              clear,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              changed,
  output logic [ACC_W-1:0]  accum,
  output logic              overrun
);

  localparam int TMR_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [TMR_W-1:0] RELOAD = TMR_W'(POLL_DIV - 1);

  typedef enum logic [1:0] {IDLE, REQ, CAPTURE} state_t;

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  timer;
  logic              tick;
  logic              pending;
  logic              leave_idle;
  logic              first;
  logic              read_req;

  logic              cap_p0;
  logic [DATA_W-1:0] data_p0;
  logic              diff_p0;

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return a + ACC_W'(b);
  endfunction

  assign avm.avm_address = ADDR_W'(READ_ADDR);
  assign avm.avm_read    = read_req;

  generate
    if (DATA_W < 32) begin : g_unused
      logic unused_rd;
      assign unused_rd = ^avm.avm_readdata[31:DATA_W];
    end
  endgenerate

  // Free-running poll timer: its period never depends on bus progress
  assign tick = enable && (timer == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer   <= RELOAD;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (enable) begin
        timer <= tick ? RELOAD : timer - 1'b1;
      end
      if (tick) begin
        pending <= 1'b1;
      end else if (leave_idle) begin
        pending <= 1'b0;
      end
      if (clear) begin
        overrun <= 1'b0;
      end else if (tick && pending) begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    read_req   = 1'b0;
    leave_idle = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          state_nxt  = REQ;
          leave_idle = 1'b1;
        end
      end
      REQ: begin
        read_req = 1'b1;
        if (!avm.avm_waitrequest) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p0: readdata is valid while in CAPTURE (fixed latency 1)
  assign cap_p0  = (state == CAPTURE);
  assign data_p0 = avm.avm_readdata[DATA_W-1:0];
  assign diff_p0 = first || (data_p0 != sample);

  // Stage p1: registered sample, pulses and accumulator; clear overrides a capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      changed      <= 1'b0;
      accum        <= '0;
      first        <= 1'b1;
    end else begin
      sample_valid <= 1'b0;
      changed      <= 1'b0;
      if (clear) begin
        sample <= '0;
        accum  <= '0;
        first  <= 1'b1;
      end else if (cap_p0) begin
        sample       <= data_p0;
        sample_valid <= 1'b1;
        changed      <= diff_p0;
        first        <= 1'b0;
        if (diff_p0) begin
          accum <= acc_add(accum, data_p0);
        end
      end
    end
  end

endmodule
